counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, width of the counter value and of each modulus input.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 req  input  2  per-requester counting request; level, held high until done or abandoned.
REQ-005 mod0  input  WIDTH  modulus requested by requester 0.
REQ-006 mod1  input  WIDTH  modulus requested by requester 1.
REQ-007 en  input  1  count enable; low pauses the active run.
REQ-008 gnt  output  2  one-hot grant; all-zero when idle.
REQ-009 busy  output  1  high whenever a run is in progress, i.e. state COUNT or DONE.
REQ-010 q  output  WIDTH  current count of the shared counter.
REQ-011 done  output  1  one-cycle pulse marking completion of a run.
REQ-012 owner  output  1  index of the most recently granted requester.

Function
REQ-013 The block SHALL use states IDLE, COUNT and DONE, with all outputs registered.
REQ-014 In IDLE, with req != 0 at an edge, the block SHALL pick a requester, set the matching gnt bit, latch its modulus into M, set q=0, update owner and enter COUNT.
REQ-015 Arbitration SHALL be round-robin: with both req bits high, grant goes to the requester other than the last served.
REQ-016 With both req bits high and no requester served since reset, arbitration SHALL grant requester 0.
REQ-017 With exactly one req bit high, that requester SHALL be granted regardless of history.
REQ-018 A latched M of 0 or 1 SHALL be treated as effective modulus 1.
REQ-019 Changes on mod0/mod1 after the grant SHALL be ignored until the next grant.
REQ-020 In COUNT with en=1 and q < M-1, q SHALL increment by 1 per cycle.
REQ-021 In COUNT, en=0 SHALL hold q and state unchanged for any number of cycles.
REQ-022 In COUNT with en=1 and q == M-1, the block SHALL set q=0, assert done and enter DONE; gnt stays asserted.
REQ-023 DONE SHALL last exactly one cycle, then return to IDLE with gnt=0 and done=0.
REQ-024 After DONE, a new grant SHALL appear no earlier than one cycle later: a mandatory one-cycle IDLE gap.
REQ-025 Timing with en held high: req sampled at edge k gives gnt at edge k, q = 0..M-1 over edges k..k+M-1, done at edge k+M, gnt=0 at edge k+M+1.
REQ-026 If the granted requester's req drops during COUNT, the block SHALL abort at the next edge: IDLE, gnt=0, q=0, no done pulse.
REQ-027 After an abort, owner SHALL still count as last served for arbitration.
REQ-028 A req bit of the non-granted requester SHALL never affect the active run.
REQ-029 q SHALL never exceed M-1, and gnt SHALL never have more than one bit set.

Reset
REQ-030 rst=1 at an edge SHALL override all other inputs and set: state=IDLE, gnt=2'b00, busy=0, q=0, done=0, owner=1.
REQ-031 owner=1 at reset is what makes the first contended grant go to requester 0.
REQ-032 rst asserted mid-run SHALL abandon the run with no done pulse; req still high after rst falls SHALL be re-arbitrated from IDLE.

Verification
REQ-033 Single run: req=2'b01, mod0=9, en=1 -> gnt=01, q counts 0..8, done pulses one cycle after q=8, gnt=00 next edge.
REQ-034 Contention: req=2'b11 held, mod0=3, mod1=5 -> grants alternate 01,10,01..., with q peaks 2,4,2 and an IDLE cycle between runs.
REQ-035 Pause: mod0=4, en low for 3 cycles at q=2 -> q holds 2, done arrives exactly 3 cycles late.
REQ-036 Abort: req0 dropped at q=5 (mod0=9) -> next edge gnt=00, q=0, no done; a pending req1 is granted after the IDLE cycle.
REQ-037 Degenerate modulus: mod1=0 and mod1=1 -> q stays 0, done one cycle after grant, run occupies 2 cycles.
REQ-038 Reset mid-run: rst=1 at q=6 -> all outputs reset at that edge, then a fresh grant after rst deasserts.

Source files
------------

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that lends a shared modulo counter to
// the granted requester for one run (count 0..M-1, then a one-cycle done).
module counter_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] mod0,
  input  logic [WIDTH-1:0] mod1,
  input  logic             en,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m, m_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] last;
  logic [1:0]       gnt_nxt;
  logic             busy_nxt, done_nxt, owner_nxt;
  logic             pick;

  // Terminal count; moduli 0 and 1 both collapse to a single-value run.
  assign last = (m <= WIDTH'(1)) ? '0 : m - WIDTH'(1);

  // Round-robin choice: contention goes to whoever was not served last,
  // a lone request wins outright.
  assign pick = (req == 2'b11) ? ~owner : req[1];

  // State and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      busy  <= 1'b0;
      q     <= '0;
      done  <= 1'b0;
      owner <= 1'b1;  // makes the first contended grant go to requester 0
      m     <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
      owner <= owner_nxt;
      m     <= m_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    q_nxt     = q;
    done_nxt  = 1'b0;
    owner_nxt = owner;
    m_nxt     = m;
    case (state)
      IDLE: begin
        gnt_nxt = 2'b00;
        q_nxt   = '0;
        if (req != 2'b00) begin
          owner_nxt = pick;
          gnt_nxt   = pick ? 2'b10 : 2'b01;
          m_nxt     = pick ? mod1 : mod0;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (!req[owner]) begin
          // Granted requester walked away: abort silently.
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
          q_nxt     = '0;
        end else if (en) begin
          if (q >= last) begin
            q_nxt     = '0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            q_nxt = q + WIDTH'(1);
          end
        end
      end
      DONE: begin
        // Unconditional return gives the mandatory idle gap between runs.
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
        q_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
        q_nxt     = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: a vector table for reset, a single run
// and contention, then hand-written sequences for pause, abort, degenerate
// moduli and mid-run reset.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] mod0, mod1;
  logic       en;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] q;
  logic       done;
  logic       owner;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  counter_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .mod0(mod0), .mod1(mod1), .en(en),
    .gnt(gnt), .busy(busy), .q(q), .done(done), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] m0;
    logic [3:0] m1;
    logic       en;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] q;
    logic       done;
    logic       owner;
  } vec_t;

  vec_t vecs[$];

  // Queue one cycle: inputs applied before the edge, outputs expected after it.
  task automatic add(input logic r, input logic [1:0] rq, input logic [3:0] a,
                     input logic [3:0] b, input logic e, input logic [1:0] eg,
                     input logic eb, input logic [3:0] eq, input logic ed,
                     input logic eo);
    vec_t v;
    v.rst = r; v.req = rq; v.m0 = a; v.m1 = b; v.en = e;
    v.gnt = eg; v.busy = eb; v.q = eq; v.done = ed; v.owner = eo;
    vecs.push_back(v);
  endtask

  // Drive one cycle and compare all outputs one time unit after the edge.
  task automatic step(input logic r, input logic [1:0] rq, input logic [3:0] a,
                      input logic [3:0] b, input logic e, input logic [1:0] eg,
                      input logic eb, input logic [3:0] eq, input logic ed,
                      input logic eo);
    logic [8:0] act, exp_v;
    rst = r; req = rq; mod0 = a; mod1 = b; en = e;
    @(posedge clk);
    #1;
    step_no++;
    act   = {gnt, busy, q, done, owner};
    exp_v = {eg, eb, eq, ed, eo};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL step%0d: got gnt=%b busy=%b q=%0d done=%b owner=%b, want gnt=%b busy=%b q=%0d done=%b owner=%b",
               step_no, gnt, busy, q, done, owner, eg, eb, eq, ed, eo);
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; mod0 = 4'd0; mod1 = 4'd0; en = 1'b0;

    // Reset, including reset overriding live requests.
    add(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    add(1, 2'b11, 9, 9, 1, 2'b00, 0, 0, 0, 1);
    // Single run, mod0=9.
    add(0, 2'b01, 9, 0, 1, 2'b01, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 2'b01, 9, 0, 1, 2'b01, 1, 4'(i), 0, 0);
    add(0, 2'b01, 9, 0, 1, 2'b01, 1, 0, 1, 0);   // done
    add(0, 2'b01, 9, 0, 1, 2'b00, 0, 0, 0, 0);   // forced idle gap
    add(0, 2'b01, 9, 0, 1, 2'b01, 1, 0, 0, 0);   // regrant
    add(0, 2'b00, 9, 0, 1, 2'b00, 0, 0, 0, 0);   // abort, no done
    // Contention after fresh reset; mod1 changed mid-run must be ignored.
    add(1, 2'b00, 3, 5, 1, 2'b00, 0, 0, 0, 1);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 0, 0, 0);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 1, 0, 0);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 2, 0, 0);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 0, 1, 0);
    add(0, 2'b11, 3, 5, 1, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 3, 5, 1, 2'b10, 1, 0, 0, 1);
    for (int i = 1; i <= 4; i++)
      add(0, 2'b11, 3, 2, 1, 2'b10, 1, 4'(i), 0, 1);
    add(0, 2'b11, 3, 2, 1, 2'b10, 1, 0, 1, 1);
    add(0, 2'b11, 3, 5, 1, 2'b00, 0, 0, 0, 1);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 0, 0, 0);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 1, 0, 0);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 2, 0, 0);
    add(0, 2'b11, 3, 5, 1, 2'b01, 1, 0, 1, 0);
    add(0, 2'b00, 3, 5, 1, 2'b00, 0, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].req, vecs[i].m0, vecs[i].m1, vecs[i].en,
           vecs[i].gnt, vecs[i].busy, vecs[i].q, vecs[i].done, vecs[i].owner);

    // Pause: lone req0 wins despite owner=0; en low 3 cycles at q=2,
    // req1 noise during the pause has no effect.
    step(0, 2'b01, 4, 0, 1, 2'b01, 1, 0, 0, 0);
    step(0, 2'b01, 4, 0, 1, 2'b01, 1, 1, 0, 0);
    step(0, 2'b01, 4, 0, 1, 2'b01, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 2'b11, 4, 0, 0, 2'b01, 1, 2, 0, 0);
    step(0, 2'b01, 4, 0, 1, 2'b01, 1, 3, 0, 0);
    step(0, 2'b01, 4, 0, 1, 2'b01, 1, 0, 1, 0);
    step(0, 2'b00, 4, 0, 1, 2'b00, 0, 0, 0, 0);

    // Abort at q=5 with req1 pending, then degenerate moduli 0 and 1.
    step(0, 2'b01, 9, 0, 1, 2'b01, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 2'b01, 9, 0, 1, 2'b01, 1, 4'(i), 0, 0);
    step(0, 2'b10, 9, 0, 1, 2'b00, 0, 0, 0, 0);
    step(0, 2'b10, 9, 0, 1, 2'b10, 1, 0, 0, 1);
    step(0, 2'b10, 9, 0, 1, 2'b10, 1, 0, 1, 1);
    step(0, 2'b10, 9, 1, 1, 2'b00, 0, 0, 0, 1);
    step(0, 2'b10, 9, 1, 1, 2'b10, 1, 0, 0, 1);
    step(0, 2'b10, 9, 1, 1, 2'b10, 1, 0, 1, 1);
    step(0, 2'b00, 9, 1, 1, 2'b00, 0, 0, 0, 1);

    // Aborted requester still counts as last served.
    step(0, 2'b11, 9, 9, 1, 2'b01, 1, 0, 0, 0);
    step(0, 2'b11, 9, 9, 1, 2'b01, 1, 1, 0, 0);
    step(0, 2'b10, 9, 9, 1, 2'b00, 0, 0, 0, 0);
    step(0, 2'b11, 9, 9, 1, 2'b10, 1, 0, 0, 1);
    for (int i = 1; i <= 6; i++)
      step(0, 2'b11, 9, 9, 1, 2'b10, 1, 4'(i), 0, 1);
    // Reset at q=6, then a fresh grant from IDLE.
    step(1, 2'b11, 9, 9, 1, 2'b00, 0, 0, 0, 1);
    step(0, 2'b11, 9, 9, 1, 2'b01, 1, 0, 0, 0);
    step(0, 2'b11, 9, 9, 1, 2'b01, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
